// File: rtl/fml_ram_slave_pkg.sv
// rtl/fml_ram_slave_pkg.sv - shared widths, FSM states and counter helpers for fml_ram_slave
package fml_ram_slave_pkg;

  localparam int FML_ADR_W = 26;
  localparam int FML_DAT_W = 32;
  localparam int CNT_W     = 16;

  localparam logic [CNT_W-1:0] CNT_ONE = 16'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_STALL = 2'd3
  } state_t;

  // Reload value for a down-counter that spans n cycles; n of 0 collapses to 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return (n > 0) ? CNT_W'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/fml_ram_bytewe.sv
// rtl/fml_ram_bytewe.sv - single-port RAM with per-byte write enable and registered read
module fml_ram_bytewe #(
  parameter int adr_w = 10,
  parameter int dat_w = 32
) (
  input  logic               clk,
  input  logic [dat_w/8-1:0] we,
  input  logic [adr_w-1:0]   adr,
  input  logic [dat_w-1:0]   wdata,
  output logic [dat_w-1:0]   rdata
);

  localparam int NB = dat_w / 8;

  logic [dat_w-1:0] mem [0:(1<<adr_w)-1];

  // Read-first: rdata reflects the word before a same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[adr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[adr];
  end

endmodule

// File: rtl/fml_ram_slave.sv
// rtl/fml_ram_slave.sv - block-RAM FML responder with fixed latency and emulated refresh stalls
module fml_ram_slave
  import fml_ram_slave_pkg::*;
#(
  parameter int adr_width     = FML_ADR_W,
  parameter int dat_width     = FML_DAT_W,
  parameter int mem_adr_width = 10,
  parameter int latency       = 3,
  parameter int stall_period  = 0,
  parameter int stall_cycles  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fml_rd,
  input  logic                   fml_wr,
  input  logic [adr_width-1:0]   fml_adr,
  input  logic [dat_width-1:0]   fml_din,
  input  logic [dat_width/8-1:0] fml_msk,
  output logic                   fml_done,
  output logic [dat_width-1:0]   fml_dout,
  output logic                   busy,
  output logic                   err
);

  localparam int MSK_W = dat_width / 8;

  localparam logic [CNT_W-1:0] LAT_LOAD    = cnt_load(latency);
  localparam logic [CNT_W-1:0] STALL_LOAD  = cnt_load(stall_cycles);
  localparam logic [CNT_W-1:0] PERIOD_LAST = cnt_load(stall_period);

  state_t                   state;
  logic [CNT_W-1:0]         lat_cnt;
  logic [CNT_W-1:0]         stall_cnt;
  logic [CNT_W-1:0]         stall_left;
  logic                     stall_pend;
  logic                     stall_expire;
  logic                     req;
  logic                     wr_q;
  logic                     done_q;
  logic                     err_q;
  logic [mem_adr_width-1:0] adr_q;
  logic [mem_adr_width-1:0] ram_adr;
  logic [dat_width-1:0]     din_q;
  logic [dat_width-1:0]     dout_q;
  logic [dat_width-1:0]     ram_rdata;
  logic [MSK_W-1:0]         msk_q;
  logic [MSK_W-1:0]         ram_we;
  logic                     unused_adr;

  assign req          = fml_rd | fml_wr;
  assign stall_expire = (stall_period != 0) && (stall_cycles != 0) && (stall_cnt == PERIOD_LAST);
  assign unused_adr   = &{1'b0, fml_adr[1:0], fml_adr[adr_width-1:mem_adr_width+2]};

  // In IDLE the RAM already looks up the incoming address so latency 1 has data ready in DONE.
  assign ram_adr = (state == ST_IDLE) ? fml_adr[mem_adr_width+1:2] : adr_q;

  // Big-endian lane order: msk[0] guards the most significant byte.
  always_comb begin
    ram_we = '0;
    for (int i = 0; i < MSK_W; i++) begin
      ram_we[i] = (state == ST_DONE) && wr_q && !msk_q[MSK_W-1-i];
    end
  end

  fml_ram_bytewe #(
    .adr_w (mem_adr_width),
    .dat_w (dat_width)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .adr   (ram_adr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_period != 0) begin
      stall_cnt <= (stall_cnt == PERIOD_LAST) ? '0 : stall_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (fml_rd && fml_wr) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      stall_left <= '0;
      stall_pend <= 1'b0;
      adr_q      <= '0;
      din_q      <= '0;
      msk_q      <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (stall_expire) stall_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (stall_pend || stall_expire) begin
            state      <= ST_STALL;
            stall_left <= STALL_LOAD;
            stall_pend <= 1'b0;
          end else if (req) begin
            adr_q   <= fml_adr[mem_adr_width+1:2];
            din_q   <= fml_din;
            msk_q   <= fml_msk;
            wr_q    <= ~fml_rd;
            lat_cnt <= LAT_LOAD;
            if (latency <= 1) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          if (lat_cnt <= CNT_ONE) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!wr_q) dout_q <= ram_rdata;
          state <= ST_IDLE;
        end
        ST_STALL: begin
          // The IDLE cycle that took the stall counts as its first cycle.
          if (stall_left <= CNT_ONE) state <= ST_IDLE;
          else stall_left <= stall_left - CNT_ONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fml_done = done_q;
  assign fml_dout = (state == ST_DONE && !wr_q) ? ram_rdata : dout_q;
  assign busy     = (state != ST_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_fml_ram_slave.sv
// tb/tb_fml_ram_slave.sv - directed bench for fml_ram_slave: latency, masks, aliasing, stalls, err, reset abort
module tb_fml_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        fml_rd, fml_wr, s_rd;
  logic [25:0] fml_adr;
  logic [31:0] fml_din;
  logic [3:0]  fml_msk;
  logic        fml_done, busy, err;
  logic [31:0] fml_dout;
  logic        s_done, s_busy, s_err;
  logic [31:0] s_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fml_ram_slave dut (
    .clk(clk), .reset(reset), .fml_rd(fml_rd), .fml_wr(fml_wr),
    .fml_adr(fml_adr), .fml_din(fml_din), .fml_msk(fml_msk),
    .fml_done(fml_done), .fml_dout(fml_dout), .busy(busy), .err(err)
  );

  fml_ram_slave #(.stall_period(20), .stall_cycles(8)) dut_s (
    .clk(clk), .reset(reset), .fml_rd(s_rd), .fml_wr(1'b0),
    .fml_adr(fml_adr), .fml_din(fml_din), .fml_msk(fml_msk),
    .fml_done(s_done), .fml_dout(s_dout), .busy(s_busy), .err(s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Raises a request, counts edges until fml_done, then drops it on the done-cycle negedge.
  task automatic xfer(input logic rd, input logic wr, input logic [25:0] adr,
                      input logic [31:0] din, input logic [3:0] msk,
                      input int exp_k, input string tag, output logic [31:0] rdata);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    fml_rd = rd; fml_wr = wr; fml_adr = adr; fml_din = din; fml_msk = msk;
    while (!seen && k < 50) begin
      @(posedge clk); #1;
      k++;
      seen = fml_done;
    end
    rdata = fml_dout;
    check({tag, "_lat"}, k, exp_k);
    @(negedge clk);
    fml_rd = 1'b0;
    fml_wr = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int k;
    int done_seen;
    bit seen;

    reset = 1'b0; fml_rd = 1'b0; fml_wr = 1'b0; s_rd = 1'b0;
    fml_adr = '0; fml_din = '0; fml_msk = '0;
    repeat (3) @(negedge clk);
    check("rst_done", fml_done, 0);
    check("rst_dout", fml_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_s_busy", s_busy, 0);
    reset = 1'b1;

    // Stall counter hits 19 after edge 19; a request seen at edge 20 waits out the 8-cycle stall.
    repeat (19) @(posedge clk);
    @(negedge clk);
    s_rd = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 50) begin
      @(posedge clk); #1;
      k++;
      seen = s_done;
      if (k == 2) check("stall_busy", s_busy, 1);
    end
    check("stall_lat", k, 11);
    @(negedge clk);
    s_rd = 1'b0;

    xfer(1'b0, 1'b1, 26'h10, 32'hDEADBEEF, 4'b0000, 3, "wr1", r);
    @(posedge clk); #1;
    check("done_pulse", fml_done, 0);
    xfer(1'b1, 1'b0, 26'h10, 32'h0, 4'b0000, 3, "rd1", r);
    check("rd1_data", r, 32'hDEADBEEF);
    @(negedge clk);

    xfer(1'b0, 1'b1, 26'h20, 32'hFFFFFFFF, 4'b0000, 3, "wfull", r);
    @(negedge clk);
    xfer(1'b0, 1'b1, 26'h20, 32'h00000000, 4'b0101, 3, "wmsk", r);
    check("dout_hold_wr", fml_dout, 32'hDEADBEEF);
    @(negedge clk);
    xfer(1'b1, 1'b0, 26'h20, 32'h0, 4'b0000, 3, "rmsk", r);
    check("rmsk_data", r, 32'hFF00FF00);

    // Chained requests: one transaction per latency+1 cycles.
    xfer(1'b0, 1'b1, 26'h1000, 32'h12345678, 4'b0000, 4, "walias", r);
    xfer(1'b1, 1'b0, 26'h0000, 32'h0, 4'b0000, 4, "ralias", r);
    check("ralias_data", r, 32'h12345678);
    xfer(1'b1, 1'b0, 26'h1003, 32'h0, 4'b0000, 4, "rlow", r);
    check("rlow_data", r, 32'h12345678);
    @(negedge clk);

    xfer(1'b0, 1'b1, 26'h40, 32'hA5A5A5A5, 4'b0000, 3, "wa5", r);
    check("err_pre", err, 0);
    @(negedge clk);
    xfer(1'b1, 1'b1, 26'h10, 32'h00000000, 4'b0000, 3, "both", r);
    check("both_data", r, 32'hDEADBEEF);
    check("err_set", err, 1);
    @(negedge clk);
    xfer(1'b1, 1'b0, 26'h10, 32'h0, 4'b0000, 3, "rd_after_both", r);
    check("rd_after_both_data", r, 32'hDEADBEEF);
    check("err_sticky", err, 1);
    @(negedge clk);

    fml_wr = 1'b1; fml_adr = 26'h40; fml_din = 32'h55555555; fml_msk = 4'b0000;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_busy_pre", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    fml_wr = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_err_clr", err, 0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (fml_done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    @(negedge clk);
    reset = 1'b1;
    check("abort_dout_rst", fml_dout, 0);
    @(negedge clk);
    xfer(1'b1, 1'b0, 26'h40, 32'h0, 4'b0000, 3, "rd_abort", r);
    check("rd_abort_data", r, 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
